clarvi_store_collector: RTL and testbench
=========================================

// Module: clarvi_store_collector
//
// PURPOSE
// Downstream end of the byte-sliced datapath: decode issues each instruction as eight 8-bit
// parts (instr_part 0..7). This block sits after EX and turns one store's eight slices of
// effective address and rs2 data back into a single 64-bit Avalon-style memory write with
// byte enables, reporting misaligned addresses and stalling the pipeline while the bus is busy.
//
// PARAMETERS
// XLEN     64  architectural register/address width
// SLICE    8   datapath slice width; NPARTS = XLEN/SLICE = 8 (part index is 3 bits)
//
// PORTS
// clock                 in   1      rising-edge clock
// reset_n               in   1      asynchronous active-low reset
// part_valid            in   1      slice of a STORE presented this cycle (EX valid && memory_write)
// part_index            in   3      instr_part of the slice (stores always ascend 0..7)
// part_addr             in   8      effective-address slice (bits 8*i+7:8*i)
// part_data             in   8      rs2 data slice (bits 8*i+7:8*i)
// part_width            in   2      mem_width_t: 0 byte, 1 half, 2 word, 3 double (sampled at part 7)
// flush                 in   1      discard store being collected (trap/branch squash)
// main_wait             in   1      bus waitrequest
// main_address          out  64     byte address of write (addr[2:0] forced to 0)
// main_byte_enable      out  8      byte lanes written
// main_write_data       out  64     lane-aligned write data
// main_write_enable     out  1      write request, held until accepted
// stall_for_store       out  1      upstream must hold its current part
// store_address_error   out  1      one-cycle pulse: misaligned store dropped
// store_sequence_error  out  1      one-cycle pulse: out-of-order part, store dropped
//
// BEHAVIOUR
// - Reset: all outputs 0, state COLLECT, expected part 0, assembly registers cleared.
// - COLLECT: slice accepted when part_valid && !stall_for_store && part_index == expected;
//   written into addr/data byte i; expected increments, wrapping 7 -> 0.
// - part_index != expected while part_valid: pulse store_sequence_error, clear, expected = 0.
// - On accepting part 7 (cycle N): a = addr[2:0], w = part_width.
//   misaligned = (a & ((1<<w)-1)) != 0 -> error pulse at N+1, no write, stay COLLECT.
//   else at N+1: state ISSUE, main_write_enable=1, main_byte_enable = ((1<<(1<<w))-1) << a,
//   main_write_data = data << (8*a) (64-bit, upper bits dropped), main_address = {addr[63:3],3'b0}.
// - ISSUE: outputs stable while main_wait; write completes on first edge with
//   main_write_enable && !main_wait; next cycle main_write_enable=0, state COLLECT.
// - stall_for_store = part_valid && state==ISSUE && !(accepting this cycle) (no buffer build).
// - flush: in COLLECT clears partial store, expected = 0; flush with part_valid same cycle:
//   flush wins, slice dropped. Flush never aborts ISSUE (bus transfers are not cancellable).
// - Error pulses and write issue are mutually exclusive; errors never raise stall.
// - Async reset mid-ISSUE drops main_write_enable immediately; the transfer is lost.
//
// CONFIGURATION
// CLARVI_STORE_BUFFER_EN defined: one-entry buffer; the next store is collected during ISSUE
//   into a second assembly register, stall_for_store only when that is also complete
//   (part 7 held) and ISSUE not finishing; buffered write issues the cycle after completion.
//   flush clears only the entry still collecting, never a completed buffered store.
// Undefined: single assembly register, collection blocked for the whole of ISSUE.
//
// TESTING
// 1. SD addr 0x1000 data 0x1122334455667788, main_wait=0 -> one-cycle write, be 0xFF, data same, addr 0x1000.
// 2. SB addr 0x1003 data 0xAB -> be 0x08, write_data[31:24]=0xAB, addr 0x1000, one write.
// 3. SW addr 0x1002 -> store_address_error high exactly one cycle, main_write_enable never high.
// 4. SH addr 0x2006, main_wait high 3 cycles -> enable/addr/be 0xC0 stable 4 cycles; next store's part 0 sees stall.
// 5. flush after part 3, then SD addr 0x3000 -> only one write, to 0x3000, correct data.
// 6. parts 0,1,3 -> store_sequence_error pulse at part 3; following clean store writes normally.
// 7. (BUFFER_EN) two back-to-back SDs, main_wait 10 cycles -> second collects without stall, two writes in order.

Source files
------------

// File: rtl/clarvi_store_collector.sv
// Reassembles the eight byte slices of a store into one 64-bit Avalon-style write with byte enables.
// Define CLARVI_STORE_BUFFER_EN to add a one-entry buffer so the next store can collect during ISSUE.
module clarvi_store_collector #(
    parameter int XLEN  = 64,
    parameter int SLICE = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           part_valid,
    input  logic [$clog2(XLEN/SLICE)-1:0]  part_index,
    input  logic [SLICE-1:0]               part_addr,
    input  logic [SLICE-1:0]               part_data,
    input  logic [1:0]                     part_width,
    input  logic                           flush,
    input  logic                           main_wait,
    output logic [XLEN-1:0]                main_address,
    output logic [XLEN/8-1:0]              main_byte_enable,
    output logic [XLEN-1:0]                main_write_data,
    output logic                           main_write_enable,
    output logic                           stall_for_store,
    output logic                           store_address_error,
    output logic                           store_sequence_error
);
    localparam int NPARTS = XLEN / SLICE;
    localparam int IDX_W  = $clog2(NPARTS);
    localparam int BE_W   = XLEN / 8;
    localparam logic [IDX_W-1:0] LAST_PART = IDX_W'(NPARTS - 1);

    typedef enum logic {COLLECT, ISSUE} state_t;

    function automatic logic is_misaligned(input logic [2:0] a, input logic [1:0] w);
        logic [2:0] mask;
        mask = 3'((4'd1 << w) - 4'd1);
        return (a & mask) != 3'd0;
    endfunction

    function automatic logic [BE_W-1:0] lane_enable(input logic [2:0] a, input logic [1:0] w);
        logic [15:0] ones;
        ones = (16'd1 << (4'd1 << w)) - 16'd1;
        return BE_W'(ones << a);
    endfunction

    function automatic logic [XLEN-1:0] lane_data(input logic [XLEN-1:0] d, input logic [2:0] a);
        return d << {a, 3'b000};
    endfunction

    state_t            state, state_next;
    logic [IDX_W-1:0]  expected;
    logic [XLEN-1:0]   addr_asm, data_asm;
    logic [XLEN-1:0]   full_addr, full_data;
    logic              finishing, can_take, take_slice, accept, seq_err, last, misaligned;
    logic              new_write, issue_new;
    logic [XLEN-1:0]   fmt_address, fmt_data;
    logic [BE_W-1:0]   fmt_be;
    logic              pend_valid;

`ifdef CLARVI_STORE_BUFFER_EN
    logic              issue_pend, to_buffer;
    logic [XLEN-1:0]   pend_address, pend_data;
    logic [BE_W-1:0]   pend_be;
`else
    assign pend_valid = 1'b0;
`endif

    always_comb begin
        finishing  = (state == ISSUE) && main_write_enable && !main_wait;
`ifdef CLARVI_STORE_BUFFER_EN
        can_take   = (state == COLLECT) || !pend_valid || finishing;
`else
        can_take   = (state == COLLECT);
`endif
        stall_for_store = part_valid && !can_take;
        take_slice = part_valid && can_take && !flush;
        accept     = take_slice && (part_index == expected);
        seq_err    = take_slice && (part_index != expected);
        last       = accept && (part_index == LAST_PART);

        // The top slice arrives combinationally with part 7; everything below is already assembled.
        full_addr = addr_asm;
        full_addr[XLEN-1 -: SLICE] = part_addr;
        full_data = data_asm;
        full_data[XLEN-1 -: SLICE] = part_data;

        misaligned  = is_misaligned(full_addr[2:0], part_width);
        new_write   = last && !misaligned;
        fmt_address = {full_addr[XLEN-1:3], 3'b000};
        fmt_be      = lane_enable(full_addr[2:0], part_width);
        fmt_data    = lane_data(full_data, full_addr[2:0]);

        issue_new = new_write && ((state == COLLECT) || (finishing && !pend_valid));
`ifdef CLARVI_STORE_BUFFER_EN
        issue_pend = finishing && pend_valid;
        to_buffer  = new_write && !issue_new;
`endif

        state_next = state;
`ifdef CLARVI_STORE_BUFFER_EN
        if (issue_new || issue_pend)
`else
        if (issue_new)
`endif
            state_next = ISSUE;
        else if (finishing)
            state_next = COLLECT;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= COLLECT;
        else
            state <= state_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            expected             <= '0;
            addr_asm             <= '0;
            data_asm             <= '0;
            store_address_error  <= 1'b0;
            store_sequence_error <= 1'b0;
        end else begin
            store_address_error  <= last && misaligned;
            store_sequence_error <= seq_err;
            if (flush || seq_err) begin
                expected <= '0;
                addr_asm <= '0;
                data_asm <= '0;
            end else if (accept) begin
                expected <= expected + IDX_W'(1);
                addr_asm[int'(part_index)*SLICE +: SLICE] <= part_addr;
                data_asm[int'(part_index)*SLICE +: SLICE] <= part_data;
            end
        end
    end

    // Bus-side registers: loaded on issue, held until the slave drops waitrequest.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_address      <= '0;
            main_byte_enable  <= '0;
            main_write_data   <= '0;
            main_write_enable <= 1'b0;
`ifdef CLARVI_STORE_BUFFER_EN
        end else if (issue_pend) begin
            main_address      <= pend_address;
            main_byte_enable  <= pend_be;
            main_write_data   <= pend_data;
            main_write_enable <= 1'b1;
`endif
        end else if (issue_new) begin
            main_address      <= fmt_address;
            main_byte_enable  <= fmt_be;
            main_write_data   <= fmt_data;
            main_write_enable <= 1'b1;
        end else if (finishing) begin
            main_write_enable <= 1'b0;
        end
    end

`ifdef CLARVI_STORE_BUFFER_EN
    // Completed store waiting for the bus; flush never touches it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid   <= 1'b0;
            pend_address <= '0;
            pend_be      <= '0;
            pend_data    <= '0;
        end else if (to_buffer) begin
            pend_valid   <= 1'b1;
            pend_address <= fmt_address;
            pend_be      <= fmt_be;
            pend_data    <= fmt_data;
        end else if (issue_pend) begin
            pend_valid   <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_clarvi_store_collector.sv
// Self-checking bench for clarvi_store_collector: vector table, corner sequences, random stores vs model.
module tb_clarvi_store_collector;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        part_valid = 1'b0;
    logic [2:0]  part_index = 3'd0;
    logic [7:0]  part_addr = 8'd0;
    logic [7:0]  part_data = 8'd0;
    logic [1:0]  part_width = 2'd0;
    logic        flush = 1'b0;
    logic        main_wait = 1'b0;
    logic [63:0] main_address;
    logic [7:0]  main_byte_enable;
    logic [63:0] main_write_data;
    logic        main_write_enable;
    logic        stall_for_store;
    logic        store_address_error;
    logic        store_sequence_error;

    clarvi_store_collector dut (
        .clock(clock), .reset_n(reset_n),
        .part_valid(part_valid), .part_index(part_index), .part_addr(part_addr),
        .part_data(part_data), .part_width(part_width), .flush(flush), .main_wait(main_wait),
        .main_address(main_address), .main_byte_enable(main_byte_enable),
        .main_write_data(main_write_data), .main_write_enable(main_write_enable),
        .stall_for_store(stall_for_store), .store_address_error(store_address_error),
        .store_sequence_error(store_sequence_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] a;
        logic [7:0]  be;
        logic [63:0] d;
    } wr_t;

    typedef struct {
        logic [1:0]  w;
        logic [63:0] a;
        logic [63:0] d;
        logic        err;
        logic [63:0] ea;
        logic [7:0]  ebe;
        logic [63:0] ed;
    } vec_t;

    wr_t got_q[$];
    int  addr_errs = 0;
    int  seq_errs = 0;

    // Bus monitor: a write completes on the edge following a cycle with enable and no wait.
    always @(negedge clock) begin
        if (reset_n && main_write_enable && !main_wait)
            got_q.push_back({main_address, main_byte_enable, main_write_data});
        if (store_address_error) addr_errs++;
        if (store_sequence_error) seq_errs++;
    end

    int   checks = 0;
    int   passes = 0;
    int   stall_cycles = 0;
    logic rand_wait = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_wait) main_wait = ($urandom_range(0, 1) == 1);
    endtask

    task automatic put_part(input int idx, input logic [63:0] a, input logic [63:0] d,
                            input logic [1:0] w);
        logic st;
        int   guard;
        part_valid = 1'b1;
        part_index = 3'(idx);
        part_addr  = a[8*idx +: 8];
        part_data  = d[8*idx +: 8];
        part_width = w;
        st = 1'b1;
        guard = 0;
        while (st && guard < 500) begin
            @(negedge clock);
            st = stall_for_store;
            if (st) stall_cycles++;
            tick();
            guard++;
        end
        if (st) begin
            checks++;
            $display("FAIL stall_timeout: part %0d still stalled after %0d cycles", idx, guard);
        end
        part_valid = 1'b0;
    endtask

    task automatic send_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] w);
        for (int i = 0; i < 8; i++) put_part(i, a, d, w);
    endtask

    vec_t        tbl[10];
    wr_t         exp_q[$];
    int          nw, ne, ns, exp_errs, base, sc0;
    logic [63:0] ra, rd;
    logic [1:0]  rw;
    logic [7:0]  rbe;
    int          lo, nbytes;
    wr_t         g;

    initial begin
        tbl[0] = '{2'd3, 64'h1000, 64'h1122334455667788, 1'b0, 64'h1000, 8'hFF, 64'h1122334455667788};
        tbl[1] = '{2'd0, 64'h1003, 64'h00000000000000AB, 1'b0, 64'h1000, 8'h08, 64'h00000000AB000000};
        tbl[2] = '{2'd2, 64'h1002, 64'h0000000012345678, 1'b1, 64'h0, 8'h00, 64'h0};
        tbl[3] = '{2'd1, 64'h2006, 64'hFFEEDDCCBBAA1234, 1'b0, 64'h2000, 8'hC0, 64'h1234000000000000};
        tbl[4] = '{2'd2, 64'h4004, 64'h00000000DEADBEEF, 1'b0, 64'h4000, 8'hF0, 64'hDEADBEEF00000000};
        tbl[5] = '{2'd3, 64'h5004, 64'h0102030405060708, 1'b1, 64'h0, 8'h00, 64'h0};
        tbl[6] = '{2'd1, 64'h7001, 64'h000000000000BEEF, 1'b1, 64'h0, 8'h00, 64'h0};
        tbl[7] = '{2'd0, 64'hFFFFFFFFFFFFFFFF, 64'h000000000000005A, 1'b0, 64'hFFFFFFFFFFFFFFF8, 8'h80, 64'h5A00000000000000};
        tbl[8] = '{2'd1, 64'h123456789ABCDEF2, 64'h000000000000BEEF, 1'b0, 64'h123456789ABCDEF0, 8'h0C, 64'h00000000BEEF0000};
        tbl[9] = '{2'd2, 64'h7000, 64'h87654321CAFEF00D, 1'b0, 64'h7000, 8'h0F, 64'h87654321CAFEF00D};

        // Reset state
        #2;
        check("rst_we", main_write_enable, 0);
        check("rst_addr", main_address, 0);
        check("rst_be", main_byte_enable, 0);
        check("rst_data", main_write_data, 0);
        check("rst_aerr", store_address_error, 0);
        check("rst_serr", store_sequence_error, 0);
        check("rst_stall", stall_for_store, 0);
        #10;
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Vector table, no bus wait
        for (int i = 0; i < 10; i++) begin
            nw = got_q.size();
            ne = addr_errs;
            send_store(tbl[i].a, tbl[i].d, tbl[i].w);
            check($sformatf("tbl%0d_we_n1", i), main_write_enable, !tbl[i].err);
            check($sformatf("tbl%0d_aerr_n1", i), store_address_error, tbl[i].err);
            tick();
            check($sformatf("tbl%0d_we_n2", i), main_write_enable, 0);
            check($sformatf("tbl%0d_aerr_n2", i), store_address_error, 0);
            tick();
            check($sformatf("tbl%0d_nwrites", i), got_q.size() - nw, tbl[i].err ? 0 : 1);
            check($sformatf("tbl%0d_naerr", i), addr_errs - ne, tbl[i].err ? 1 : 0);
            if (!tbl[i].err && got_q.size() == nw + 1) begin
                check($sformatf("tbl%0d_addr", i), got_q[nw].a, tbl[i].ea);
                check($sformatf("tbl%0d_be", i), got_q[nw].be, tbl[i].ebe);
                check($sformatf("tbl%0d_data", i), got_q[nw].d, tbl[i].ed);
            end
        end

        // Half-word with three wait cycles; next store's part 0 arrives during ISSUE
        nw = got_q.size();
        main_wait = 1'b1;
        send_store(64'h2006, 64'h000000000000BEEF, 2'd1);
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                part_valid = 1'b1;
                part_index = 3'd0;
                part_addr  = 8'h00;
                part_data  = 8'h11;
                part_width = 2'd3;
            end
            check("hold_we", main_write_enable, 1);
            check("hold_addr", main_address, 64'h2000);
            check("hold_be", main_byte_enable, 8'hC0);
            check("hold_data", main_write_data, 64'hBEEF000000000000);
`ifndef CLARVI_STORE_BUFFER_EN
            check("hold_stall", stall_for_store, 1);
`endif
            if (c == 3) main_wait = 1'b0;
            tick();
        end
        check("hold_done_we", main_write_enable, 0);
        check("hold_done_stall", stall_for_store, 0);
        part_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("hold_nwrites", got_q.size() - nw, 1);

        // Flush after part 3, then a clean double-word
        nw = got_q.size();
        for (int i = 0; i < 4; i++) put_part(i, 64'h9999000, 64'hDEADDEADDEADDEAD, 2'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send_store(64'h3000, 64'hCAFEBABE0BADF00D, 2'd3);
        tick();
        tick();
        check("flush_nwrites", got_q.size() - nw, 1);
        if (got_q.size() == nw + 1) begin
            check("flush_addr", got_q[nw].a, 64'h3000);
            check("flush_data", got_q[nw].d, 64'hCAFEBABE0BADF00D);
        end

        // Flush together with a valid slice: slice dropped
        nw = got_q.size();
        ns = seq_errs;
        for (int i = 0; i < 3; i++) put_part(i, 64'h8888000, 64'h0, 2'd3);
        part_valid = 1'b1;
        part_index = 3'd3;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        part_valid = 1'b0;
        send_store(64'h3100, 64'h0123456789ABCDEF, 2'd3);
        tick();
        tick();
        check("flushv_nwrites", got_q.size() - nw, 1);
        check("flushv_nserr", seq_errs - ns, 0);
        if (got_q.size() == nw + 1) check("flushv_data", got_q[nw].d, 64'h0123456789ABCDEF);

        // Out-of-order part: 0, 1, 3
        nw = got_q.size();
        put_part(0, 64'h6000, 64'h0, 2'd3);
        put_part(1, 64'h6000, 64'h0, 2'd3);
        put_part(3, 64'h6000, 64'h0, 2'd3);
        check("seq_pulse", store_sequence_error, 1);
        check("seq_no_we", main_write_enable, 0);
        tick();
        check("seq_pulse_end", store_sequence_error, 0);
        send_store(64'h6008, 64'hA5A5A5A55A5A5A5A, 2'd3);
        tick();
        tick();
        check("seq_nwrites", got_q.size() - nw, 1);
        if (got_q.size() == nw + 1) begin
            check("seq_addr", got_q[nw].a, 64'h6008);
            check("seq_data", got_q[nw].d, 64'hA5A5A5A55A5A5A5A);
        end

        // Asynchronous reset during ISSUE drops the request at once
        nw = got_q.size();
        main_wait = 1'b1;
        send_store(64'h8000, 64'h1, 2'd3);
        check("arst_we_before", main_write_enable, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_we", main_write_enable, 0);
        check("arst_be", main_byte_enable, 0);
        #3;
        @(negedge clock);
        reset_n = 1'b1;
        main_wait = 1'b0;
        tick();
        tick();
        check("arst_nwrites", got_q.size() - nw, 0);

`ifdef CLARVI_STORE_BUFFER_EN
        // Back-to-back stores against a long wait
        nw = got_q.size();
        main_wait = 1'b1;
        send_store(64'hA000, 64'h1111111111111111, 2'd3);
        sc0 = stall_cycles;
        send_store(64'hB000, 64'h2222222222222222, 2'd3);
        check("buf_no_stall", stall_cycles - sc0, 0);
        tick();
        main_wait = 1'b0;
        for (int k = 0; k < 50 && got_q.size() < nw + 2; k++) tick();
        tick();
        check("buf_nwrites", got_q.size() - nw, 2);
        if (got_q.size() == nw + 2) begin
            check("buf_first", got_q[nw].a, 64'hA000);
            check("buf_second", got_q[nw + 1].a, 64'hB000);
            check("buf_second_data", got_q[nw + 1].d, 64'h2222222222222222);
        end
`endif

        // Random stores with random bus waits against the reference model
        base = got_q.size();
        ne = addr_errs;
        ns = seq_errs;
        exp_errs = 0;
        rand_wait = 1'b1;
        for (int n = 0; n < 60; n++) begin
            rw = 2'($urandom_range(0, 3));
            ra = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            nbytes = 1 << rw;
            if ($urandom_range(0, 3) != 0) ra = ra - 64'(int'(ra[2:0]) % nbytes);
            lo = int'(ra[2:0]);
            if (lo % nbytes != 0) begin
                exp_errs++;
            end else begin
                for (int k = 0; k < 8; k++) rbe[k] = (k >= lo) && (k < lo + nbytes);
                exp_q.push_back({ra - 64'(lo), rbe, rd << (8 * lo)});
            end
            send_store(ra, rd, rw);
            if ($urandom_range(0, 2) == 0) tick();
        end
        rand_wait = 1'b0;
        main_wait = 1'b0;
        for (int k = 0; k < 100 && main_write_enable; k++) tick();
        tick();
        check("rnd_drained", main_write_enable, 0);
        check("rnd_nwrites", got_q.size() - base, exp_q.size());
        check("rnd_naerr", addr_errs - ne, exp_errs);
        check("rnd_nserr", seq_errs - ns, 0);
        if (got_q.size() - base == exp_q.size()) begin
            for (int k = 0; k < exp_q.size(); k++) begin
                g = got_q[base + k];
                check($sformatf("rnd%0d_write", k), {g.a[7:0], g.be, g.d[47:0]},
                      {exp_q[k].a[7:0], exp_q[k].be, exp_q[k].d[47:0]});
                if (g !== exp_q[k])
                    check($sformatf("rnd%0d_full", k), g.a ^ exp_q[k].a ^ g.d ^ exp_q[k].d, 64'h0);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
